// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction-fetch and data ports onto one memory bus, data first, with an optional wait timeout.
module mem_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ce,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_stallreq,
  input  logic        d_ce,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_sel,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_stallreq,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_sel,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  output logic        bus_err
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] REQ_D  = 3'd1;
  localparam logic [2:0] RESP_D = 3'd2;
  localparam logic [2:0] REQ_I  = 3'd3;
  localparam logic [2:0] RESP_I = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        m_req_q, m_req_d, m_we_q, m_we_d, bus_err_q, bus_err_d;
  logic [31:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
  logic [3:0]  m_sel_q, m_sel_d;
  logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic        in_req, timeout, done;

  assign in_req  = (state_q == REQ_D) | (state_q == REQ_I);
  assign timeout = (TIMEOUT != 8'd0) && (cnt_q == TIMEOUT);
  assign done    = m_ack | timeout;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_sel_d   = m_sel_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    bus_err_d = 1'b0;
    if (state_q == IDLE) begin
      if (d_ce | i_ce) begin
        state_d   = d_ce ? REQ_D : REQ_I;
        cnt_d     = 8'd0;
        m_req_d   = 1'b1;
        m_we_d    = d_ce & d_we;
        m_addr_d  = d_ce ? d_addr : i_addr;
        m_sel_d   = d_ce ? d_sel : 4'hF;
        m_wdata_d = d_ce ? d_wdata : 32'd0;
      end
    end else if (in_req) begin
      if (done) begin
        state_d   = (state_q == REQ_D) ? RESP_D : RESP_I;
        m_req_d   = 1'b0;
        m_we_d    = 1'b0;
        m_addr_d  = 32'd0;
        m_sel_d   = 4'd0;
        m_wdata_d = 32'd0;
        bus_err_d = ~m_ack;
        // a timed-out read returns zero; writes never disturb d_rdata
        i_rdata_d = (state_q == REQ_I) ? (m_ack ? m_rdata : 32'd0) : i_rdata_q;
        d_rdata_d = (state_q == REQ_D && !m_we_q) ? (m_ack ? m_rdata : 32'd0) : d_rdata_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= 32'd0;
      m_sel_q   <= 4'd0;
      m_wdata_q <= 32'd0;
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_sel_q   <= m_sel_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign m_req      = m_req_q;
  assign m_we       = m_we_q;
  assign m_addr     = m_addr_q;
  assign m_sel      = m_sel_q;
  assign m_wdata    = m_wdata_q;
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign bus_err    = bus_err_q;
  assign i_stallreq = i_ce & (state_q != RESP_I);
  assign d_stallreq = d_ce & (state_q != RESP_D);
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 8'd255: cycles in a REQ state without m_ack before forced completion; 0 disables the timeout.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 i_ce  in  1  instruction-fetch request.
REQ-005 i_addr  in  32  fetch address.
REQ-006 i_rdata  out  32  fetched word (registered).
REQ-007 i_stallreq  out  1  fetch not complete; pipeline must hold.
REQ-008 d_ce  in  1  data-access request.
REQ-009 d_we  in  1  1 = write, 0 = read.
REQ-010 d_addr  in  32  data address.
REQ-011 d_sel  in  4  byte-lane enables.
REQ-012 d_wdata  in  32  write data.
REQ-013 d_rdata  out  32  read data (registered).
REQ-014 d_stallreq  out  1  data access not complete.
REQ-015 m_req  out  1  memory request, held until m_ack or timeout.
REQ-016 m_we / m_addr / m_sel / m_wdata  out  1/32/4/32  latched request fields.
REQ-017 m_rdata  in  32  memory read data, valid with m_ack.
REQ-018 m_ack  in  1  one-cycle completion strobe from memory.
REQ-019 bus_err  out  1  one-cycle pulse on timeout completion.

Function
REQ-020 FSM states: IDLE, REQ_D, RESP_D, REQ_I, RESP_I; all m_* outputs registered.
REQ-021 IDLE: d_ce=1 -> REQ_D (data priority); else i_ce=1 -> REQ_I; else stay IDLE.
REQ-022 On IDLE->REQ_x edge: latch the requester's addr/we/sel/wdata into m_*, set m_req=1; instruction requests latch m_we=0, m_sel=4'hF, m_wdata=0.
REQ-023 REQ_x: m_* held stable; m_ack=1 -> RESP_x, m_req=0, x_rdata<=m_rdata (d_rdata unchanged on writes).
REQ-024 REQ_x: wait counter (8 bit) increments each cycle without m_ack; counter==TIMEOUT and TIMEOUT!=0 -> RESP_x, x_rdata<=0, bus_err=1 during RESP_x; counter cleared on entry to every REQ state.
REQ-025 RESP_x: lasts exactly one cycle, always -> IDLE; m_req=0; m_we/m_addr/m_sel/m_wdata=0 outside REQ states.
REQ-026 i_stallreq = i_ce & (state != RESP_I); d_stallreq = d_ce & (state != RESP_D); combinational.
REQ-027 Minimum access latency: request seen in IDLE at cycle N, m_req at N+1, ack at N+1 -> RESP at N+2 (stallreq low), next request accepted at N+3.
REQ-028 No preemption: a pending d_ce during REQ_I/RESP_I waits until IDLE, then wins.
REQ-029 Requester dropping ce mid-access does not abort; access completes, rdata still updated.
REQ-030 m_ack outside REQ states is ignored.

Reset
REQ-031 rst=1 immediately (asynchronously) forces IDLE, m_req=0, all m_* = 0, i_rdata=d_rdata=0, bus_err=0, counter=0.
REQ-032 Reset during REQ_x abandons the access; a late m_ack after reset release is ignored per REQ-030.

Verification
REQ-033 Fetch only: i_ce=1, i_addr=0x100, m_ack one cycle after m_req with m_rdata=0x3C010001 -> i_rdata=0x3C010001, i_stallreq low exactly in RESP_I cycle, total 3 cycles.
REQ-034 Collision: i_ce and d_ce (read 0x200) asserted same cycle in IDLE -> m_addr=0x200 first; fetch issued only after RESP_D->IDLE.
REQ-035 Write: d_we=1, d_addr=0x40, d_sel=4'b0011, d_wdata=0xDEADBEEF -> m_* match while m_req high; d_rdata keeps prior value.
REQ-036 Timeout: TIMEOUT=4, m_ack never -> m_req drops after 4 wait cycles, bus_err one-cycle pulse, d_rdata=0.
REQ-037 Async reset mid REQ_I with m_req=1 -> m_req low before next clk edge; m_ack pulse after release produces no RESP state.
REQ-038 Wait states: m_ack delayed 7 cycles -> m_addr/m_we/m_sel/m_wdata stable for all 8 REQ cycles, stallreq high throughout.
